// File: rtl/specs_fire_monitor_if.sv
// Bundle between the SPECS checker block, the event consumer, the debug unit
// and the fire monitor. The monitor side uses the slave modport; the
// environment that drives checker levels, pops events and answers halts uses
// the master modport.
interface specs_fire_monitor_if #(
  parameter int STAMP_W = 16
);

  // Checker-side inputs
  logic               enable;
  logic [31:0]        checkers_fired;
  logic [31:0]        ex_pc;
  logic [31:0]        fire_mask;
  logic               halt_en;
  logic               clr_valid;
  logic [31:0]        clr_mask;

  // Event FIFO read port
  logic               evt_valid;
  logic               evt_ready;
  logic [31:0]        evt_pc;
  logic [31:0]        evt_bits;
  logic [STAMP_W-1:0] evt_stamp;

  // Status
  logic [31:0]        sticky;
  logic               first_valid;
  logic [4:0]         first_id;
  logic [7:0]         drop_count;

  // Halt handshake with the debug unit
  logic               halt_req;
  logic               halt_ack;
  logic               resume;
  logic               halted;

  modport slave (
    input  enable, checkers_fired, ex_pc, fire_mask, halt_en,
    input  clr_valid, clr_mask, evt_ready, halt_ack, resume,
    output evt_valid, evt_pc, evt_bits, evt_stamp,
    output sticky, first_valid, first_id, drop_count, halt_req, halted
  );

  modport master (
    output enable, checkers_fired, ex_pc, fire_mask, halt_en,
    output clr_valid, clr_mask, evt_ready, halt_ack, resume,
    input  evt_valid, evt_pc, evt_bits, evt_stamp,
    input  sticky, first_valid, first_id, drop_count, halt_req, halted
  );

endinterface

// File: rtl/specs_fire_monitor.sv
// SPECS fire monitor: turns level checker outputs into rising-edge events,
// logs {pc, bits, stamp} into a first-word-fall-through FIFO, keeps sticky
// status and the first-fired checker ID, and runs the halt-request handshake.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module specs_fire_monitor #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  specs_fire_monitor_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + 32 + STAMP_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  // State registers
  logic [31:0]        prev_q,  prev_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [31:0]        sticky_q, sticky_d;
  logic               first_valid_q, first_valid_d;
  logic [4:0]         first_id_q, first_id_d;
  logic [7:0]         drop_q, drop_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_e             state_q, state_d;
  logic               halt_req_q, halt_req_d;
  logic               halted_q, halted_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  // Combinational helpers
  logic [31:0]        masked_s;
  logic [31:0]        rise_s;
  logic               event_s;
  logic               evt_valid_s;
  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               clr_first_s;
  logic [31:0]        clr_vec_s;
  logic [ENT_W-1:0]   entry_s;
  logic [ENT_W-1:0]   head_s;

  // Edge detection: only enabled cycles can produce rises or advance prev.
  always_comb begin
    masked_s = bus.checkers_fired & bus.fire_mask;
    rise_s   = 32'd0;
    prev_d   = prev_q;
    stamp_d  = stamp_q;
    if (bus.enable) begin
      rise_s  = masked_s & ~prev_q;
      prev_d  = masked_s;
      stamp_d = stamp_q + STAMP_W'(1);
    end else begin
      rise_s  = 32'd0;
      prev_d  = prev_q;
      stamp_d = stamp_q;
    end
    event_s = (rise_s != 32'd0);
    entry_s = {bus.ex_pc, rise_s, stamp_q};
  end

  // FIFO bookkeeping: a pop in the same cycle frees room for the push.
  always_comb begin
    evt_valid_s = (count_q != CNT_W'(0));
    full_s      = (count_q == CNT_W'(DEPTH));
    pop_s       = evt_valid_s & bus.evt_ready;
    push_s      = event_s & (~full_s | pop_s);
    drop_s      = event_s & full_s & ~pop_s;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_d      = drop_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Sticky status and first-fired capture; a set beats a same-cycle clear.
  always_comb begin
    if (bus.clr_valid) begin
      clr_vec_s = bus.clr_mask;
    end else begin
      clr_vec_s = 32'd0;
    end
    sticky_d      = (sticky_q & ~clr_vec_s) | rise_s;
    clr_first_s   = first_valid_q & bus.clr_valid & bus.clr_mask[first_id_q];
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    if (event_s && (!first_valid_q || clr_first_s)) begin
      first_valid_d = 1'b1;
      first_id_d    = lowest_idx(rise_s);
    end else if (clr_first_s) begin
      first_valid_d = 1'b0;
      first_id_d    = first_id_q;
    end else begin
      first_valid_d = first_valid_q;
      first_id_d    = first_id_q;
    end
  end

  // Halt FSM next state; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (event_s && bus.halt_en) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.halt_ack) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HALTED: begin
        if (bus.resume) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    halt_req_d = (state_d == ST_REQ);
    halted_d   = (state_d == ST_HALTED);
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q        <= 32'd0;
      stamp_q       <= '0;
      sticky_q      <= 32'd0;
      first_valid_q <= 1'b0;
      first_id_q    <= 5'd0;
      drop_q        <= 8'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      halt_req_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      stamp_q       <= stamp_d;
      sticky_q      <= sticky_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      halt_req_q    <= halt_req_d;
      halted_q      <= halted_d;
    end
  end

  // Event storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // Head of the FIFO, forced to zero when empty so reset clears the outputs.
  always_comb begin
    head_s = '0;
    if (evt_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  assign bus.evt_valid   = evt_valid_s;
  assign bus.evt_pc      = head_s[ENT_W-1 -: 32];
  assign bus.evt_bits    = head_s[STAMP_W +: 32];
  assign bus.evt_stamp   = head_s[STAMP_W-1:0];
  assign bus.sticky      = sticky_q;
  assign bus.first_valid = first_valid_q;
  assign bus.first_id    = first_id_q;
  assign bus.drop_count  = drop_q;
  assign bus.halt_req    = halt_req_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_specs_fire_monitor.sv
// Self-checking bench for specs_fire_monitor: a queue-based event model is
// updated after every rising edge and compared with the DUT on every falling
// edge; directed scenarios add literal expectations, followed by random stimulus.
module tb_specs_fire_monitor;

  localparam int DEPTH   = 8;
  localparam int STAMP_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  specs_fire_monitor_if #(.STAMP_W(STAMP_W)) bus ();

  specs_fire_monitor #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        bits;
    logic [STAMP_W-1:0] stamp;
  } ev_t;

  // Behavioural model state
  ev_t                q[$];
  logic [31:0]        m_prev;
  logic [31:0]        m_sticky;
  logic [STAMP_W-1:0] m_stamp;
  logic               m_fv;
  logic [4:0]         m_fid;
  int                 m_drop;
  int                 m_st;   // 0 idle, 1 requesting, 2 halted

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  cmp_on   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge using the inputs the DUT just sampled.
  task automatic model_update();
    logic [31:0] mm, rise;
    bit ev, full, pop, clrf;
    ev_t e;
    if (!rst) begin
      q.delete();
      m_prev = 32'd0; m_sticky = 32'd0; m_stamp = '0;
      m_fv = 1'b0; m_fid = 5'd0; m_drop = 0; m_st = 0;
    end else begin
      mm   = bus.checkers_fired & bus.fire_mask;
      rise = bus.enable ? (mm & ~m_prev) : 32'd0;
      ev   = (rise != 32'd0);
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && bus.evt_ready;
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (!full || pop) begin
          e.pc = bus.ex_pc; e.bits = rise; e.stamp = m_stamp;
          q.push_back(e);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      clrf = m_fv && bus.clr_valid && bus.clr_mask[m_fid];
      m_sticky = (m_sticky & ~(bus.clr_valid ? bus.clr_mask : 32'd0)) | rise;
      if (ev && (!m_fv || clrf)) begin
        m_fv = 1'b1;
        for (int b = 0; b < 32; b++) begin
          if (rise[b]) begin
            m_fid = 5'(b);
            break;
          end
        end
      end else if (clrf) begin
        m_fv = 1'b0;
      end
      if (m_st == 0 && ev && bus.halt_en) m_st = 1;
      else if (m_st == 1 && bus.halt_ack) m_st = 2;
      else if (m_st == 2 && bus.resume) m_st = 0;
      if (bus.enable) begin
        m_prev  = mm;
        m_stamp = m_stamp + STAMP_W'(1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #2;
  endtask

  // Per-cycle comparison of every DUT output with the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("evt_valid", 64'(bus.evt_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("evt_pc", 64'(bus.evt_pc), 64'(q[0].pc));
        chk("evt_bits", 64'(bus.evt_bits), 64'(q[0].bits));
        chk("evt_stamp", 64'(bus.evt_stamp), 64'(q[0].stamp));
      end else begin
        chk("evt_pc_empty", 64'(bus.evt_pc), 64'd0);
        chk("evt_bits_empty", 64'(bus.evt_bits), 64'd0);
      end
      chk("sticky", 64'(bus.sticky), 64'(m_sticky));
      chk("first_valid", 64'(bus.first_valid), 64'(m_fv));
      chk("first_id", 64'(bus.first_id), 64'(m_fid));
      chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
      chk("halt_req", 64'(bus.halt_req), 64'(m_st == 1));
      chk("halted", 64'(bus.halted), 64'(m_st == 2));
    end
  end

  // Drain the FIFO, return the FSM to IDLE and leave prev at zero.
  task automatic settle();
    bus.checkers_fired = 32'd0; bus.enable = 1'b1; bus.evt_ready = 1'b1;
    bus.fire_mask = 32'hFFFF_FFFF; bus.halt_en = 1'b0; bus.clr_valid = 1'b0;
    bus.halt_ack = 1'b1; bus.resume = 1'b0;
    step();
    bus.halt_ack = 1'b0; bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  logic [31:0] cf_r;

  initial begin
    bus.enable = 1'b0; bus.checkers_fired = 32'd0; bus.ex_pc = 32'd0;
    bus.fire_mask = 32'hFFFF_FFFF; bus.halt_en = 1'b0; bus.clr_valid = 1'b0;
    bus.clr_mask = 32'd0; bus.evt_ready = 1'b0; bus.halt_ack = 1'b0; bus.resume = 1'b0;
    rst = 1'b0;
    step();
    cmp_on = 1'b1;
    step();
    chk("reset_evt_valid", 64'(bus.evt_valid), 64'd0);
    chk("reset_sticky", 64'(bus.sticky), 64'd0);
    chk("reset_halt_req", 64'(bus.halt_req), 64'd0);

    // Single rising bit, held for three cycles
    rst = 1'b1;
    bus.checkers_fired = 32'h4; bus.ex_pc = 32'h100; bus.enable = 1'b1;
    chk("t1_pre_valid", 64'(bus.evt_valid), 64'd0);
    step();
    chk("t1_valid", 64'(bus.evt_valid), 64'd1);
    chk("t1_pc", 64'(bus.evt_pc), 64'h100);
    chk("t1_bits", 64'(bus.evt_bits), 64'h4);
    chk("t1_stamp", 64'(bus.evt_stamp), 64'd0);
    chk("t1_sticky", 64'(bus.sticky), 64'h4);
    chk("t1_first_id", 64'(bus.first_id), 64'd2);
    step(); step();
    chk("t1_one_entry", 64'(bus.evt_bits), 64'h4);
    settle();

    // First-id clear without event, then halt handshake
    bus.clr_valid = 1'b1; bus.clr_mask = 32'h4;
    step();
    chk("t2_first_cleared", 64'(bus.first_valid), 64'd0);
    bus.clr_valid = 1'b0; bus.checkers_fired = 32'h22; bus.halt_en = 1'b1;
    step();
    chk("t2_bits", 64'(bus.evt_bits), 64'h22);
    chk("t2_first_id", 64'(bus.first_id), 64'd1);
    chk("t2_halt_req", 64'(bus.halt_req), 64'd1);
    bus.halt_ack = 1'b1;
    step();
    chk("t2_halted", 64'(bus.halted), 64'd1);
    chk("t2_req_drop", 64'(bus.halt_req), 64'd0);
    bus.halt_ack = 1'b0; bus.resume = 1'b1;
    step();
    chk("t2_resumed", 64'(bus.halted), 64'd0);
    bus.resume = 1'b0; bus.checkers_fired = 32'h2A;
    step();
    chk("t2_rereq", 64'(bus.halt_req), 64'd1);
    settle();

    // Overflow: DEPTH+3 events with no consumer, then pop+push while full
    bus.evt_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      bus.checkers_fired = 32'd1 << i; bus.ex_pc = 32'h200 + 32'(i);
      step();
    end
    chk("t3_drop", 64'(bus.drop_count), 64'd3);
    chk("t3_head", 64'(bus.evt_bits), 64'h1);
    bus.checkers_fired = 32'd1 << (DEPTH + 3); bus.evt_ready = 1'b1;
    step();
    chk("t3_drop_hold", 64'(bus.drop_count), 64'd3);
    chk("t3_next_head", 64'(bus.evt_bits), 64'h2);
    settle();

    // Sticky clear vs same-cycle set
    bus.clr_valid = 1'b1; bus.clr_mask = 32'h4;
    step();
    chk("t4_cleared", 64'(bus.sticky[2]), 64'd0);
    bus.checkers_fired = 32'h4;
    step();
    chk("t4_set_wins", 64'(bus.sticky[2]), 64'd1);
    settle();

    // Enable gating and masking
    bus.enable = 1'b0; bus.checkers_fired = 32'h8;
    step(); step();
    chk("t5_no_event", 64'(bus.evt_valid), 64'd0);
    bus.enable = 1'b1;
    step();
    chk("t5_event", 64'(bus.evt_bits), 64'h8);
    chk("t5_stamp_frozen", 64'(bus.evt_stamp), 64'(m_stamp - STAMP_W'(1)));
    bus.checkers_fired = 32'd0;
    step();
    bus.fire_mask = 32'hFFFF_FFF7; bus.checkers_fired = 32'h8;
    step();
    chk("t5_masked", 64'(bus.evt_valid), 64'd0);
    settle();

    // Reset during REQ with two queued entries
    bus.evt_ready = 1'b0; bus.halt_en = 1'b1; bus.checkers_fired = 32'h1;
    step();
    bus.checkers_fired = 32'h3;
    step();
    chk("t6_req", 64'(bus.halt_req), 64'd1);
    rst = 1'b0;
    step();
    chk("t6_halt_req", 64'(bus.halt_req), 64'd0);
    chk("t6_evt_valid", 64'(bus.evt_valid), 64'd0);
    chk("t6_sticky", 64'(bus.sticky), 64'd0);
    chk("t6_drop", 64'(bus.drop_count), 64'd0);
    rst = 1'b1;
    settle();

    // Random traffic
    cf_r = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: cf_r = cf_r;
        1: cf_r = cf_r ^ (32'd1 << $urandom_range(0, 31));
        2: cf_r = cf_r ^ (32'd1 << $urandom_range(0, 31)) ^ (32'd1 << $urandom_range(0, 31));
        default: cf_r = $urandom & $urandom & $urandom;
      endcase
      bus.checkers_fired = cf_r;
      bus.ex_pc     = $urandom;
      bus.enable    = ($urandom_range(0, 7) != 0);
      bus.evt_ready = ($urandom_range(0, 2) != 0);
      bus.fire_mask = ($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF;
      bus.halt_en   = $urandom_range(0, 1) != 0;
      bus.clr_valid = ($urandom_range(0, 9) == 0);
      bus.clr_mask  = $urandom;
      bus.halt_ack  = ($urandom_range(0, 3) == 0);
      bus.resume    = ($urandom_range(0, 5) == 0);
      rst           = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1;
    settle();

    // Drop counter saturation
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 270; i++) begin
      bus.checkers_fired = 32'd1 << (i % 32);
      step();
    end
    chk("sat_drop", 64'(bus.drop_count), 64'd255);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
